// File: rtl/vm_match_engine.sv
// VM match engine: walks every projection/stub pair of one event and writes z/phi matches as index pairs.
// Optional build macro VM_MATCH_Z_NEIGHBOUR_EN widens the z test to |z_p - z_s| <= 1.
module vm_match_engine #(
    parameter int ADDR_W  = 9,
    parameter int PHI_WIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_proc,
    input  logic [ADDR_W:0]       n_proj,
    input  logic [ADDR_W:0]       n_stub,
    output logic [ADDR_W-1:0]     read_projection,
    input  logic [12:0]           vm_projection,
    output logic [ADDR_W-1:0]     read_stub,
    input  logic [12:0]           vm_stub,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     write_match,
    output logic [2*ADDR_W-1:0]   match,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0]   N_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [9:0]        WIN   = 10'(PHI_WIN);

    state_t            state;
    logic [ADDR_W:0]   np_l, ns_l;
    logic              drain_cnt;
    logic              v1;
    logic [ADDR_W-1:0] pi_d, si_d;
    logic              full;
    logic              last_stub, last_proj;
    logic              hit;
    logic [3:0]        z_p, z_s;
    logic [9:0]        phi_p, phi_s, dphi;
    logic              z_ok;

    assign last_stub = ({1'b0, read_stub} == (ns_l - N_ONE));
    assign last_proj = ({1'b0, read_projection} == (np_l - N_ONE));

    always_comb begin
        z_p   = vm_projection[12:9];
        z_s   = vm_stub[12:9];
        phi_p = {1'b0, vm_projection[8:0]};
        phi_s = {1'b0, vm_stub[8:0]};
        dphi  = (phi_p >= phi_s) ? (phi_p - phi_s) : (phi_s - phi_p);
`ifdef VM_MATCH_Z_NEIGHBOUR_EN
        z_ok  = (((z_p >= z_s) ? (z_p - z_s) : (z_s - z_p)) <= 4'd1);
`else
        z_ok  = (z_p == z_s);
`endif
        hit   = v1 && z_ok && (dphi <= WIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            np_l            <= '0;
            ns_l            <= '0;
            drain_cnt       <= 1'b0;
            v1              <= 1'b0;
            pi_d            <= '0;
            si_d            <= '0;
            full            <= 1'b0;
            read_projection <= '0;
            read_stub       <= '0;
            wr_en           <= 1'b0;
            write_match     <= '0;
            match           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            // Stage 1: the address pair issued last cycle, aligned with the returning memory data.
            v1    <= (state == RUN);
            pi_d  <= read_projection;
            si_d  <= read_stub;
            if (wr_en) begin
                write_match <= write_match + A_ONE;
                if (&write_match) full <= 1'b1;
            end
            if (hit) begin
                if (full || (wr_en && (&write_match))) begin
                    overflow <= 1'b1;
                end else begin
                    wr_en <= 1'b1;
                    match <= {pi_d, si_d};
                end
            end
            case (state)
                IDLE: begin
                    if (en_proc) begin
                        np_l        <= n_proj;
                        ns_l        <= n_stub;
                        write_match <= '0;
                        overflow    <= 1'b0;
                        full        <= 1'b0;
                        busy        <= 1'b1;
                        if (n_proj == '0 || n_stub == '0) begin
                            state <= DONE;
                        end else begin
                            read_projection <= '0;
                            read_stub       <= '0;
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!last_stub) begin
                        read_stub <= read_stub + A_ONE;
                    end else if (!last_proj) begin
                        read_stub       <= '0;
                        read_projection <= read_projection + A_ONE;
                    end else begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) state <= DONE;
                    drain_cnt <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vm_match_engine.sv
// Bench for vm_match_engine: pair-list model of each event checked every cycle, plus literal expectations.
module tb_vm_match_engine;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en_proc = 1'b0;
    logic [AW:0]     n_proj = '0;
    logic [AW:0]     n_stub = '0;
    logic [AW-1:0]   read_projection, read_stub, write_match;
    logic [12:0]     vm_projection, vm_stub;
    logic            wr_en, busy, done, overflow;
    logic [2*AW-1:0] match;

    logic [12:0] pmem [8];
    logic [12:0] smem [8];

    int total = 0;
    int bad   = 0;

    int rel = 999;
    int end_rel = 0;
    int drop_rel = 2000;
    int ns_m = 1;
    bit          ew  [64];
    logic [5:0]  em  [64];
    logic [2:0]  ewa [64];

    int         obs_wr = 0;
    logic [5:0] last_m = '0;
    int         last_wr_rel = -1;
    bit         xw;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vm_projection <= pmem[read_projection];
        vm_stub       <= smem[read_stub];
    end

    vm_match_engine #(.ADDR_W(AW), .PHI_WIN(4)) dut (
        .clk(clk), .reset(rst), .en_proc(en_proc), .n_proj(n_proj), .n_stub(n_stub),
        .read_projection(read_projection), .vm_projection(vm_projection),
        .read_stub(read_stub), .vm_stub(vm_stub), .wr_en(wr_en), .write_match(write_match),
        .match(match), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pair_match(input logic [12:0] p, input logic [12:0] s);
        int dz, dp;
        dz = int'(p[12:9]) - int'(s[12:9]);
        if (dz < 0) dz = -dz;
        dp = int'(p[8:0]) - int'(s[8:0]);
        if (dp < 0) dp = -dp;
`ifdef VM_MATCH_Z_NEIGHBOUR_EN
        return (dz <= 1) && (dp <= 4);
`else
        return (dz == 0) && (dp <= 4);
`endif
    endfunction

    // Expected event: pair j is addressed at relative cycle j, its write (if any) lands at j+2.
    function automatic void build_model();
        int n, cnt, pi, si;
        n    = int'(n_proj) * int'(n_stub);
        ns_m = (n_stub == '0) ? 1 : int'(n_stub);
        for (int i = 0; i < 64; i++) begin
            ew[i] = 1'b0; em[i] = '0; ewa[i] = '0;
        end
        drop_rel = 2000;
        cnt = 0;
        for (int j = 0; j < n; j++) begin
            pi = j / ns_m;
            si = j % ns_m;
            if (pair_match(pmem[pi[2:0]], smem[si[2:0]])) begin
                if (cnt < 8) begin
                    ew[j+2]  = 1'b1;
                    em[j+2]  = {pi[2:0], si[2:0]};
                    ewa[j+2] = cnt[2:0];
                end else if (drop_rel == 2000) begin
                    drop_rel = j + 2;
                end
                cnt++;
            end
        end
        end_rel = (n == 0) ? 1 : n + 3;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rel = 999; end_rel = 0; drop_rel = 2000;
        end else if (en_proc && rel >= end_rel) begin
            build_model();
            rel = 0;
        end else if (rel < 999) begin
            rel = rel + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_wr_en", wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_write_match", write_match, 0);
            chk("rst_match", match, 0);
            chk("rst_read_projection", read_projection, 0);
            chk("rst_read_stub", read_stub, 0);
        end else begin
            xw = (rel < 64) ? ew[rel] : 1'b0;
            chk("wr_en", wr_en, xw);
            if (xw && wr_en) begin
                chk("match", match, em[rel]);
                chk("write_match", write_match, ewa[rel]);
            end
            chk("done", done, rel == end_rel);
            chk("busy", busy, rel < end_rel);
            chk("overflow", overflow, rel >= drop_rel);
            if (rel < end_rel - 3) begin
                chk("read_projection", read_projection, rel / ns_m);
                chk("read_stub", read_stub, rel % ns_m);
            end
            if (wr_en) begin
                obs_wr++;
                last_m = match;
                last_wr_rel = rel;
            end
        end
    end

    task automatic start_event(input int np, input int ns);
        @(negedge clk);
        n_proj  = np[AW:0];
        n_stub  = ns[AW:0];
        obs_wr  = 0;
        last_wr_rel = -1;
        en_proc = 1'b1;
        @(negedge clk);
        en_proc = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_rel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_done_cycle"}, rel, exp_rel);
    endtask

    task automatic run_event(input string name, input int np, input int ns, input int exp_rel, input int exp_wr);
        start_event(np, ns);
        wait_done(name, exp_rel);
        chk({name, "_writes"}, obs_wr, exp_wr);
    endtask

    initial begin
        int zn;
        for (int i = 0; i < 8; i++) begin
            pmem[i] = '0; smem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        pmem[0] = {4'd3, 9'd100}; smem[0] = {4'd3, 9'd104};
        run_event("t1", 1, 1, 4, 1);
        chk("t1_match", last_m, 6'd0);
        chk("t1_write_cycle", last_wr_rel, 2);

        smem[0] = {4'd3, 9'd105};
        run_event("t2", 1, 1, 4, 0);
        chk("t2_overflow", overflow, 0);

        pmem[0] = {4'd3, 9'd104}; smem[0] = {4'd3, 9'd100};
        run_event("t2b", 1, 1, 4, 1);

        pmem[0] = {4'd1, 9'd50};  pmem[1] = {4'd2, 9'd200};
        smem[0] = {4'd2, 9'd300}; smem[1] = {4'd1, 9'd60}; smem[2] = {4'd2, 9'd198};
        run_event("t3", 2, 3, 9, 1);
        chk("t3_match", last_m, 6'o12);
        chk("t3_write_cycle", last_wr_rel, 7);

        run_event("t4", 0, 5, 1, 0);
        chk("t4_read_projection_held", read_projection, 1);
        chk("t4_read_stub_held", read_stub, 2);
        run_event("t4b", 2, 0, 1, 0);

        for (int i = 0; i < 3; i++) begin
            pmem[i] = {4'd7, 9'd10}; smem[i] = {4'd7, 9'd10};
        end
        start_event(3, 3);
        repeat (2) @(negedge clk);
        en_proc = 1'b1;
        @(negedge clk);
        en_proc = 1'b0;
        wait_done("t5", 12);
        chk("t5_writes", obs_wr, 8);
        chk("t5_overflow", overflow, 1);
        repeat (3) @(negedge clk);
        chk("t5_overflow_sticky", overflow, 1);

        start_event(3, 3);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_wr_en", wr_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_match", match, 0);
        chk("t6_read_stub", read_stub, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        obs_wr = 0;
        repeat (4) @(negedge clk);
        chk("t6_no_writes_after_reset", obs_wr, 0);

        pmem[0] = {4'd5, 9'd1}; smem[0] = {4'd5, 9'd510}; smem[1] = {4'd5, 9'd5};
        run_event("t7", 1, 2, 5, 1);
        chk("t7_match", last_m, 6'd1);

`ifdef VM_MATCH_Z_NEIGHBOUR_EN
        zn = 1;
`else
        zn = 0;
`endif
        pmem[0] = {4'd4, 9'd50}; smem[0] = {4'd5, 9'd50}; smem[1] = {4'd6, 9'd50};
        run_event("t8", 1, 2, 5, zn);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
